// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray/binary conversion helpers and default width
// Functions work on a 32-bit container; callers zero-extend narrower values
// and truncate the result. Zero upper bits leave the lower-bit results unchanged.
package gray_pkg;

  localparam int GRAY_N_DEFAULT = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down: bin[i] = ^gray[31:i].
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_nbits.sv
// rtl/gray2bin_nbits.sv - combinational N-bit Gray to binary converter
// Ports:
//   gray_i  in  N  Gray-coded value
//   bin_o   out N  binary equivalent (prefix XOR from the MSB)
module gray2bin_nbits #(
  parameter int N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[N-1:i];
  end

endmodule

// File: rtl/gray_updown_counter_nbits.sv
// rtl/gray_updown_counter_nbits.sv - N-bit up/down Gray counter with load and wrap/saturate
// Ports:
//   clk       in   1  rising-edge clock
//   rst       in   1  synchronous active-high reset (highest priority)
//   clk_en    in   1  step enable
//   up        in   1  1 = count up, 0 = count down
//   load      in   1  synchronous load strobe (beats clk_en)
//   load_val  in   N  Gray-coded value to load
//   gray_out  out  N  Gray view of the count register
//   bin_out   out  N  binary view of the count register
//   at_max    out  1  count is all ones
//   at_min    out  1  count is zero
//   wrap      out  1  one-cycle pulse after a step that wrapped
module gray_updown_counter_nbits
  import gray_pkg::*;
#(
  parameter int          N        = GRAY_N_DEFAULT,
  parameter bit          SATURATE = 1'b0,
  parameter logic [N-1:0] RST_GRAY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         up,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         at_max,
  output logic         at_min,
  output logic         wrap
);

  localparam logic [N-1:0] RST_BIN = N'(gray2bin(32'(RST_GRAY)));

  logic [N-1:0] cnt_q, cnt_d;
  logic         wrap_q, wrap_d;
  logic [N-1:0] load_bin;

  gray2bin_nbits #(.N(N)) u_load_g2b (
    .gray_i (load_val),
    .bin_o  (load_bin)
  );

  // Terminal flags decode the register only, so no input reaches an output.
  assign at_max   = (cnt_q == {N{1'b1}});
  assign at_min   = (cnt_q == '0);
  assign gray_out = cnt_q ^ (cnt_q >> 1);
  assign bin_out  = cnt_q;
  assign wrap     = wrap_q;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = load_bin;
    end else if (clk_en) begin
      if (up) begin
        if (!(at_max && SATURATE)) begin
          cnt_d  = cnt_q + N'(1);
          wrap_d = at_max;
        end
      end else begin
        if (!(at_min && SATURATE)) begin
          cnt_d  = cnt_q - N'(1);
          wrap_d = at_min;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_BIN;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

endmodule
